// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the queued entry layout.
// Build option DECODE_ILLEGAL_TRAP_EN adds an illegal-encoding flag to each entry.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        to_rs;
        logic        to_lsb;
        logic        is_store;
        logic        use_rs1;
        logic        use_rs2;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } dq_entry_t;

    // Unknown opcodes fall into FMT_R so they carry a zero immediate.
    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OPC_LUI, OPC_AUIPC:                                 f = FMT_U;
            OPC_JAL:                                            f = FMT_J;
            OPC_BRANCH:                                         f = FMT_B;
            OPC_STORE:                                          f = FMT_S;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM: f = FMT_I;
            default:                                            f = FMT_R;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator plus routing/use flags for one instruction word.
// With DECODE_ILLEGAL_TRAP_EN it also flags encodings outside RV32I.
module decode_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [31:0] imm,
    output logic        to_rs,
    output logic        to_lsb,
    output logic        is_store,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic [6:0] op;
    assign op = inst[6:0];

    always_comb begin
        case (fmt_of(op))
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        to_rs    = 1'b0;
        to_lsb   = 1'b0;
        is_store = 1'b0;
        use_rs1  = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
        use_rs2  = (op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_OP_IMM, OPC_OP:  to_rs = 1'b1;
            OPC_LOAD:                        to_lsb = 1'b1;
            OPC_STORE: begin
                to_lsb   = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic known_op;
    logic f7_form;
    logic f7_ok;

    always_comb begin
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: known_op = 1'b1;
            default:                                              known_op = 1'b0;
        endcase
        // Shift-immediates (funct3 001/101) reuse the funct7 field like OP.
        f7_form = (op == OPC_OP) || (op == OPC_OP_IMM && inst[13:12] == 2'b01);
        f7_ok   = (inst[31:25] == 7'b0000000) || (inst[31:25] == 7'b0100000);
        illegal = !known_op || (f7_form && !f7_ok);
    end
`endif

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between ifetch and dispatch, resolving head operands against RF/ROB.
// Build option DECODE_ILLEGAL_TRAP_EN adds the out_illegal port.
module decode_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic [4:0]       rs1_index,
    output logic [4:0]       rs2_index,
    input  logic             rs1_dirty,
    input  logic             rs2_dirty,
    input  logic [ROB_W-1:0] rs1_rob_entry,
    input  logic [ROB_W-1:0] rs2_rob_entry,
    input  logic [31:0]      rs1_value,
    input  logic [31:0]      rs2_value,
    output logic [ROB_W-1:0] rs1_rob_q_entry,
    output logic [ROB_W-1:0] rs2_rob_q_entry,
    input  logic             rs1_rob_rdy,
    input  logic             rs2_rob_rdy,
    input  logic [31:0]      rs1_rob_value,
    input  logic [31:0]      rs2_rob_value,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic             out_illegal,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic             out_funct7b,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_rs1_val,
    output logic [31:0]      out_rs2_val,
    output logic             out_rs1_need_rob,
    output logic             out_rs2_need_rob,
    output logic [ROB_W-1:0] out_rs1_rob_id,
    output logic [ROB_W-1:0] out_rs2_rob_id,
    output logic             out_to_rs,
    output logic             out_to_lsb,
    output logic             out_is_store
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dq_entry_t        mem [DEPTH];
    dq_entry_t        new_e;
    dq_entry_t        head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    decode_imm_gen u_imm_gen (
        .inst     (in_inst),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal  (new_e.illegal),
`endif
        .imm      (new_e.imm),
        .to_rs    (new_e.to_rs),
        .to_lsb   (new_e.to_lsb),
        .is_store (new_e.is_store),
        .use_rs1  (new_e.use_rs1),
        .use_rs2  (new_e.use_rs2)
    );

    assign new_e.opcode  = in_inst[6:0];
    assign new_e.funct3  = in_inst[14:12];
    assign new_e.funct7b = in_inst[30];
    assign new_e.rs1     = in_inst[19:15];
    assign new_e.rs2     = in_inst[24:20];
    assign new_e.pc      = in_pc;
    assign new_e.rd      = (in_inst[6:0] == OPC_BRANCH || in_inst[6:0] == OPC_STORE) ? 5'd0 : in_inst[11:7];

    assign out_valid = (count != '0);
    assign in_ready  = (count < CW'(DEPTH)) || (out_valid && out_ready);
    assign push      = in_valid && in_ready && rdy && !rollback;
    assign pop       = out_valid && out_ready && rdy && !rollback;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (rollback) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Payload is deliberately not reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_e;
    end

    assign head            = mem[rd_ptr];
    assign rs1_index       = head.rs1;
    assign rs2_index       = head.rs2;
    assign rs1_rob_q_entry = rs1_rob_entry;
    assign rs2_rob_q_entry = rs2_rob_entry;

    always_comb begin
        out_rs1_val      = '0;
        out_rs1_need_rob = 1'b0;
        out_rs1_rob_id   = '0;
        if (head.use_rs1) begin
            if (!rs1_dirty)      out_rs1_val = rs1_value;
            else if (rs1_rob_rdy) out_rs1_val = rs1_rob_value;
            else begin
                out_rs1_need_rob = 1'b1;
                out_rs1_rob_id   = rs1_rob_entry;
            end
        end
    end

    always_comb begin
        out_rs2_val      = '0;
        out_rs2_need_rob = 1'b0;
        out_rs2_rob_id   = '0;
        if (head.use_rs2) begin
            if (!rs2_dirty)      out_rs2_val = rs2_value;
            else if (rs2_rob_rdy) out_rs2_val = rs2_rob_value;
            else begin
                out_rs2_need_rob = 1'b1;
                out_rs2_rob_id   = rs2_rob_entry;
            end
        end
    end

    assign out_opcode   = head.opcode;
    assign out_funct3   = head.funct3;
    assign out_funct7b  = head.funct7b;
    assign out_rd       = head.rd;
    assign out_imm      = head.imm;
    assign out_pc       = head.pc;
    assign out_to_rs    = head.to_rs;
    assign out_to_lsb   = head.to_lsb;
    assign out_is_store = head.is_store;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign out_illegal  = head.illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed scenarios followed by randomized traffic.
// Covers the out_illegal port when DECODE_ILLEGAL_TRAP_EN is defined.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int ROB_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, rdy, rollback, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_inst, in_pc;
    logic [4:0]       rs1_index, rs2_index;
    logic             rs1_dirty, rs2_dirty, rs1_rob_rdy, rs2_rob_rdy;
    logic [ROB_W-1:0] rs1_rob_entry, rs2_rob_entry, rs1_rob_q_entry, rs2_rob_q_entry;
    logic [31:0]      rs1_value, rs2_value, rs1_rob_value, rs2_rob_value;
    logic [6:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic             out_funct7b;
    logic [4:0]       out_rd;
    logic [31:0]      out_imm, out_pc, out_rs1_val, out_rs2_val;
    logic             out_rs1_need_rob, out_rs2_need_rob;
    logic [ROB_W-1:0] out_rs1_rob_id, out_rs2_rob_id;
    logic             out_to_rs, out_to_lsb, out_is_store;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             out_illegal;
`endif

    decode_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_dirty(rs1_dirty), .rs2_dirty(rs2_dirty),
        .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_rob_q_entry(rs1_rob_q_entry), .rs2_rob_q_entry(rs2_rob_q_entry),
        .rs1_rob_rdy(rs1_rob_rdy), .rs2_rob_rdy(rs2_rob_rdy),
        .rs1_rob_value(rs1_rob_value), .rs2_rob_value(rs2_rob_value),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .out_illegal(out_illegal),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b(out_funct7b),
        .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rs1_need_rob(out_rs1_need_rob), .out_rs2_need_rob(out_rs2_need_rob),
        .out_rs1_rob_id(out_rs1_rob_id), .out_rs2_rob_id(out_rs2_rob_id),
        .out_to_rs(out_to_rs), .out_to_lsb(out_to_lsb), .out_is_store(out_is_store)
    );

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
        logic        to_rs, to_lsb, is_store, use1, use2, illegal;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA tables: imm built from signed field values.
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   v;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        e.opcode = w[6:0]; e.funct3 = w[14:12]; e.f7b = w[30];
        e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.pc = pc;
        e.imm = 0; e.to_rs = 0; e.to_lsb = 0; e.is_store = 0;
        e.use1 = 1; e.use2 = 0; e.illegal = 0;
        i12 = w[31:20];
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h37, 7'h17: begin e.imm = w & 32'hFFFFF000; e.to_rs = 1; e.use1 = 0; end
            7'h6F: begin v = j21; e.imm = v; e.to_rs = 1; e.use1 = 0; end
            7'h67: begin v = i12; e.imm = v; e.to_rs = 1; end
            7'h63: begin v = b13; e.imm = v; e.to_rs = 1; e.use2 = 1; e.rd = 0; end
            7'h03: begin v = i12; e.imm = v; e.to_lsb = 1; end
            7'h23: begin
                i12 = {w[31:25], w[11:7]}; v = i12; e.imm = v;
                e.to_lsb = 1; e.is_store = 1; e.use2 = 1; e.rd = 0;
            end
            7'h13: begin
                v = i12; e.imm = v; e.to_rs = 1;
                if ((w[14:12] == 3'd1 || w[14:12] == 3'd5) && w[31:25] != 7'h00 && w[31:25] != 7'h20)
                    e.illegal = 1;
            end
            7'h33: begin
                e.to_rs = 1; e.use2 = 1;
                if (w[31:25] != 7'h00 && w[31:25] != 7'h20) e.illegal = 1;
            end
            7'h0F, 7'h73: begin v = i12; e.imm = v; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    task automatic exp_op(input logic use_s, dirty, robrdy, input logic [ROB_W-1:0] ent,
                          input logic [31:0] rfv, robv,
                          output logic [31:0] val, output logic need, output logic [ROB_W-1:0] id);
        val = 0; need = 0; id = 0;
        if (use_s) begin
            if (!dirty) val = rfv;
            else if (robrdy) val = robv;
            else begin need = 1; id = ent; end
        end
    endtask

    // Model state advance: applies the same handshake rules to the expected queue.
    always @(posedge clk) begin
        int n;
        n = exp_q.size();
        if (rst) exp_q.delete();
        else if (rdy) begin
            if (rollback) exp_q.delete();
            else begin
                if (n != 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && (n < DEPTH || (n != 0 && out_ready)))
                    exp_q.push_back(model_decode(in_inst, in_pc));
            end
        end
    end

    // Monitor: compares the presented head against the scoreboard front.
    always @(negedge clk) begin
        int n;
        exp_t e;
        logic [31:0] v;
        logic need;
        logic [ROB_W-1:0] id;
        if (!rst) begin
            n = exp_q.size();
            chk("out_valid", 32'(out_valid), 32'(n != 0));
            chk("in_ready", 32'(in_ready), 32'((n < DEPTH) || (n != 0 && out_ready)));
            if (n != 0 && out_valid) begin
                e = exp_q[0];
                chk("opcode", 32'(out_opcode), 32'(e.opcode));
                chk("funct3", 32'(out_funct3), 32'(e.funct3));
                chk("funct7b", 32'(out_funct7b), 32'(e.f7b));
                chk("rd", 32'(out_rd), 32'(e.rd));
                chk("imm", out_imm, e.imm);
                chk("pc", out_pc, e.pc);
                chk("to_rs", 32'(out_to_rs), 32'(e.to_rs));
                chk("to_lsb", 32'(out_to_lsb), 32'(e.to_lsb));
                chk("is_store", 32'(out_is_store), 32'(e.is_store));
                chk("rs1_index", 32'(rs1_index), 32'(e.rs1));
                chk("rs2_index", 32'(rs2_index), 32'(e.rs2));
`ifdef DECODE_ILLEGAL_TRAP_EN
                chk("illegal", 32'(out_illegal), 32'(e.illegal));
`endif
                exp_op(e.use1, rs1_dirty, rs1_rob_rdy, rs1_rob_entry, rs1_value, rs1_rob_value, v, need, id);
                chk("rs1_val", out_rs1_val, v);
                chk("rs1_need", 32'(out_rs1_need_rob), 32'(need));
                if (need || !e.use1) chk("rs1_id", 32'(out_rs1_rob_id), 32'(id));
                exp_op(e.use2, rs2_dirty, rs2_rob_rdy, rs2_rob_entry, rs2_value, rs2_rob_value, v, need, id);
                chk("rs2_val", out_rs2_val, v);
                chk("rs2_need", 32'(out_rs2_need_rob), 32'(need));
                if (need || !e.use2) chk("rs2_id", 32'(out_rs2_rob_id), 32'(id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  ops [11];
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom();
        k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = ops[k];
        if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        rst = 1; rdy = 1; rollback = 0; in_valid = 0; out_ready = 0;
        in_inst = 0; in_pc = 0;
        rs1_dirty = 0; rs2_dirty = 0; rs1_rob_rdy = 0; rs2_rob_rdy = 0;
        rs1_rob_entry = 0; rs2_rob_entry = 0;
        rs1_value = 0; rs2_value = 0; rs1_rob_value = 0; rs2_rob_value = 0;
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);

        // addi x1,x0,5
        step();
        in_inst = 32'h00500093; in_pc = 32'h100; in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_imm", out_imm, 5);
        chk("addi_rd", 32'(out_rd), 1);
        chk("addi_to_rs", 32'(out_to_rs), 1);
        chk("addi_rs1_val", out_rs1_val, 0);
        step(); out_ready = 1; step(); out_ready = 0;

        // sw x2,-4(x1) with rs2 pending in ROB entry 3
        in_inst = 32'hFE20AE23; in_pc = 32'h104; in_valid = 1;
        step();
        in_valid = 0; rs2_dirty = 1; rs2_rob_entry = 3; rs2_rob_rdy = 0;
        @(negedge clk);
        chk("sw_need_rob", 32'(out_rs2_need_rob), 1);
        chk("sw_rob_id", 32'(out_rs2_rob_id), 3);
        chk("sw_rd", 32'(out_rd), 0);
        chk("sw_is_store", 32'(out_is_store), 1);
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        step(); out_ready = 1; step(); out_ready = 0; rs2_dirty = 0;

        // Fill, then simultaneous push/pop while full
        in_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            in_inst = 32'h00100093 + (i << 20); in_pc = 32'h200 + 4 * i;
            step();
        end
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        step();
        out_ready = 1;
        @(negedge clk);
        chk("full_popping_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            in_pc = 32'h300 + 4 * i;
            @(negedge clk);
            chk("full_pp_in_ready", 32'(in_ready), 1);
            chk("full_pp_valid", 32'(out_valid), 1);
        end
        step();
        out_ready = 0; in_valid = 0;
        @(negedge clk);
        chk("still_full", 32'(in_ready), 0);
        out_ready = 1;
        repeat (DEPTH) step();
        out_ready = 0;
        @(negedge clk);
        chk("drained", 32'(out_valid), 0);

        // Rollback discards queue and the concurrent push
        step();
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin in_pc = 32'h400 + 4 * i; step(); end
        rollback = 1; in_pc = 32'h4F0;
        step();
        rollback = 0; in_valid = 0;
        @(negedge clk);
        chk("rollback_valid", 32'(out_valid), 0);
        chk("rollback_in_ready", 32'(in_ready), 1);
        step();
        @(negedge clk);
        chk("rollback_lost", 32'(out_valid), 0);

        // rdy low freezes everything
        in_valid = 1; in_inst = 32'h00208133;
        in_pc = 32'h500; step(); in_pc = 32'h504; step();
        rdy = 0; out_ready = 1; in_pc = 32'h508;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_pc", out_pc, 32'h500);
            chk("stall_in_ready", 32'(in_ready), 1);
        end
        rdy = 1; in_valid = 0;
        step(); step();
        out_ready = 0;
        @(negedge clk);
        chk("stall_drained", 32'(out_valid), 0);

        // Unknown opcode
        in_inst = 32'h0000007F; in_pc = 32'h600; in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("unk_to_rs", 32'(out_to_rs), 0);
        chk("unk_to_lsb", 32'(out_to_lsb), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("unk_illegal", 32'(out_illegal), 1);
`endif
        step(); out_ready = 1; step(); out_ready = 0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            rdy           = ($urandom_range(0, 9) < 8);
            rollback      = ($urandom_range(0, 39) == 0);
            in_valid      = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 6);
            in_inst       = rand_inst();
            in_pc         = $urandom() & 32'hFFFFFFFC;
            rs1_dirty     = $urandom_range(0, 1) == 1;
            rs2_dirty     = $urandom_range(0, 1) == 1;
            rs1_rob_rdy   = $urandom_range(0, 1) == 1;
            rs2_rob_rdy   = $urandom_range(0, 1) == 1;
            rs1_rob_entry = ROB_W'($urandom());
            rs2_rob_entry = ROB_W'($urandom());
            rs1_value     = $urandom();
            rs2_value     = $urandom();
            rs1_rob_value = $urandom();
            rs2_rob_value = $urandom();
            step();
        end
        rst = 0; rdy = 1; rollback = 0; in_valid = 0; out_ready = 1;
        repeat (DEPTH + 2) step();
        @(negedge clk);
        chk("final_empty", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
